// File: rtl/abs_dif_pkg.sv
// Shared types and default sizing for the absolute-difference SAD accumulator.
package abs_dif_pkg;

  localparam int unsigned W_DEF     = 4;
  localparam int unsigned N_DEF     = 4;
  localparam int unsigned ACC_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/mux21.sv
// Two-input W-bit multiplexer used to select the non-negative difference.
module mux21 #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/abs_dif_sad.sv
// Frame-based sum of absolute differences over N operand pairs with a ready/valid result.
// Define ABS_DIF_SAT_EN to saturate the accumulator and report a sticky ovf flag.
module abs_dif_sad
  import abs_dif_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state;
  state_e           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             ovf_sum;
  logic [W-1:0]     d0;
  logic [W-1:0]     d1;
  logic [W-1:0]     absd;
  logic             sel;
  logic             accept;
  logic             last;
  logic             done;

  assign d0  = a - b;
  assign d1  = b - a;
  assign sel = (a < b);

  mux21 #(.W(W)) u_mux21 (
    .in0 (d0),
    .in1 (d1),
    .sel (sel),
    .out (absd)
  );

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);
  assign done   = out_valid && out_ready;

`ifdef ABS_DIF_SAT_EN
  logic [ACC_W:0] wide;

  // One extra carry bit detects overflow; clamp to all-ones and latch ovf.
  always_comb begin
    wide = {1'b0, acc} + (ACC_W + 1)'(absd);
    if (wide[ACC_W]) begin
      acc_sum = '1;
      ovf_sum = 1'b1;
    end else begin
      acc_sum = wide[ACC_W-1:0];
      ovf_sum = ovf_q;
    end
  end
`else
  always_comb begin
    acc_sum = acc + ACC_W'(absd);
    ovf_sum = 1'b0;
  end
`endif

  // Accumulator, pair count and overflow flag; clr wins over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (clr || done) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc   <= acc_sum;
      cnt   <= cnt + CNT_W'(1);
      ovf_q <= ovf_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = ACC;
        ACC:     if (accept && last) state_nxt = OUT;
        OUT:     if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      OUT: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign sad = acc;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_abs_dif_sad.sv
// Directed bench for abs_dif_sad: default instance plus an ACC_W=5 instance for overflow behaviour.
module tb_abs_dif_sad;

  logic       clk;
  logic       rst_n;
  logic       clr,  clr2;
  logic [3:0] a,    b,    a2,   b2;
  logic       in_valid,  in_valid2;
  logic       in_ready,  in_ready2;
  logic [5:0] sad;
  logic [4:0] sad2;
  logic       out_valid, out_valid2;
  logic       out_ready, out_ready2;
  logic       ovf,  ovf2;

  int vectors;
  int miscompares;

`ifdef ABS_DIF_SAT_EN
  localparam int EXP3 = 31;
  localparam int EXP4 = 31;
  localparam logic EOVF = 1'b1;
`else
  localparam int EXP3 = 13;
  localparam int EXP4 = 28;
  localparam logic EOVF = 1'b0;
`endif

  abs_dif_sad dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .sad(sad), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  abs_dif_sad #(.W(4), .N(4), .ACC_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .a(a2), .b(b2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sad(sad2), .out_valid(out_valid2), .out_ready(out_ready2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y);
    a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [3:0] x, input logic [3:0] y);
    a2 = x; b2 = y; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++; if (sad !== 6'd0) begin miscompares++; $display("FAIL reset_sad got %0d want 0", sad); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(4'd9, 4'd3);
    vectors++; if (sad !== 6'd6) begin miscompares++; $display("FAIL basic_first got %0d want 6", sad); end
    send(4'd2, 4'd7);
    vectors++; if (sad !== 6'd11) begin miscompares++; $display("FAIL basic_second got %0d want 11", sad); end
    send(4'd5, 4'd5);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    send(4'd0, 4'd15);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    vectors++; if (sad !== 6'd26) begin miscompares++; $display("FAIL basic_sad got %0d want 26", sad); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready got %b want 0", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_idle got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    vectors++; if (sad !== 6'd0) begin miscompares++; $display("FAIL basic_cleared got %0d want 0", sad); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd9, 4'd3); send(4'd2, 4'd7); send(4'd5, 4'd5); send(4'd0, 4'd15);
    // Offer a pair while stalled; it must not be taken.
    a = 4'd15; b = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (sad !== 6'd26 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d] got sad=%0d ov=%b want 26/1", i, sad, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    vectors++; if (in_ready !== 1'b1 || sad !== 6'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got ir=%b sad=%0d ov=%b want 1/0/0", in_ready, sad, out_valid); end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    send(4'd9, 4'd3);
    repeat (3) step();
    vectors++; if (sad !== 6'd6) begin miscompares++; $display("FAIL gap_hold got %0d want 6", sad); end
    send(4'd2, 4'd7);
    repeat (3) step();
    send(4'd5, 4'd5);
    repeat (3) step();
    vectors++; if (sad !== 6'd11 || out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_mid got sad=%0d ov=%b want 11/0", sad, out_valid); end
    send(4'd0, 4'd15);
    vectors++; if (sad !== 6'd26 || out_valid !== 1'b1) begin miscompares++; $display("FAIL gap_final got sad=%0d ov=%b want 26/1", sad, out_valid); end
    step();
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    send(4'd9, 4'd3); send(4'd2, 4'd7);
    clr = 1'b1; a = 4'd0; b = 4'd15; in_valid = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    vectors++; if (sad !== 6'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_abort got sad=%0d ir=%b ov=%b want 0/1/0", sad, in_ready, out_valid); end
    send(4'd1, 4'd4); send(4'd8, 4'd2); send(4'd3, 4'd3);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_count got ov=%b want 0", out_valid); end
    send(4'd10, 4'd0);
    vectors++; if (sad !== 6'd19 || out_valid !== 1'b1) begin miscompares++; $display("FAIL clr_fresh got sad=%0d ov=%b want 19/1", sad, out_valid); end
    step();
  endtask

  task automatic test_ovf();
    out_ready2 = 1'b1;
    send2(4'd15, 4'd0); send2(4'd15, 4'd0);
    vectors++; if (sad2 !== 5'd30 || ovf2 !== 1'b0) begin miscompares++; $display("FAIL ovf_two got sad=%0d ovf=%b want 30/0", sad2, ovf2); end
    send2(4'd15, 4'd0);
    vectors++; if (sad2 !== 5'(EXP3) || ovf2 !== EOVF) begin miscompares++; $display("FAIL ovf_three got sad=%0d ovf=%b want %0d/%b", sad2, ovf2, EXP3, EOVF); end
    send2(4'd15, 4'd0);
    vectors++; if (sad2 !== 5'(EXP4) || ovf2 !== EOVF || out_valid2 !== 1'b1) begin miscompares++; $display("FAIL ovf_final got sad=%0d ovf=%b ov=%b want %0d/%b/1", sad2, ovf2, out_valid2, EXP4, EOVF); end
    step();
    vectors++; if (sad2 !== 5'd0 || ovf2 !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared got sad=%0d ovf=%b want 0/0", sad2, ovf2); end
  endtask

  task automatic test_reset_in_out();
    out_ready = 1'b0;
    send(4'd9, 4'd3); send(4'd2, 4'd7); send(4'd5, 4'd5); send(4'd0, 4'd15);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre got ov=%b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || sad !== 6'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_out got ov=%b sad=%0d ir=%b want 0/0/1", out_valid, sad, in_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || sad !== 6'd0) begin miscompares++; $display("FAIL rst_after got ov=%b sad=%0d want 0/0", out_valid, sad); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clr = 1'b0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
    clr2 = 1'b0; a2 = '0; b2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_clr();
    test_ovf();
    test_reset_in_out();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
